// File: rtl/riscv_boot_pkg.sv
// Shared types and constants for the boot loader slice.
package riscv_boot_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR_CNT,
        HDR_BASE,
        DATA,
        WRITE,
        CHECK,
        RUN,
        HALT,
        ERROR
    } boot_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SIZE = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    // COUNT (4 bytes) followed by BASE (4 bytes)
    localparam int unsigned HDR_BYTES = 8;

endpackage

// File: rtl/riscv_boot_word_asm.sv
// Little-endian byte-to-word assembler. The assembled word is presented
// combinationally together with the completing byte, so the loader can
// latch it on the same edge the last byte is accepted.
module riscv_boot_word_asm
    import riscv_boot_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            push_i,
    input  logic [7:0]      byte_i,
    output logic [XLEN-1:0] word_o,
    output logic            full_o
);

    localparam int unsigned BPW = XLEN / 8;
    localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

    // Holds the previous BPW-1 bytes; the newest byte always enters at the top.
    logic [XLEN-9:0] shift_q;
    logic [CW-1:0]   cnt_q;

    assign word_o = {byte_i, shift_q};
    assign full_o = push_i && (cnt_q == CW'(BPW - 1));

    // Shift in accepted bytes and count them modulo BPW.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (push_i) begin
            shift_q <= word_o[XLEN-1:8];
            cnt_q   <= full_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_boot_loader.sv
// Framed-image loader: parses MAGIC/COUNT/BASE/data/CSUM from a byte
// stream, writes words to memory, then releases (and optionally freezes)
// the core.
module riscv_boot_loader
    import riscv_boot_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MAX_WORDS  = 4096,
    parameter int unsigned RUN_CYCLES = 4000,
    parameter logic [7:0]  MAGIC      = 8'hA5
) (
    input  logic              i_riscv_boot_loader_clk,
    input  logic              i_riscv_boot_loader_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_ready,
    output logic              o_core_rst_n,
    output logic              o_core_en,
    output logic              o_done,
    output logic [1:0]        o_err,
    output logic              o_halt
);

    localparam int unsigned BPW       = XLEN / 8;
    localparam logic [31:0] RUN_LAST  = 32'(RUN_CYCLES) - 32'd1;
    localparam logic [2:0]  CNT_LAST  = 3'(HDR_BYTES / 2 - 1);
    localparam logic [2:0]  BASE_LAST = 3'(HDR_BYTES - 1);

    boot_state_e       state_q;
    logic [23:0]       hdr_q;
    logic [31:0]       hdr_d;
    logic [2:0]        hdr_idx_q;
    logic [31:0]       count_q;
    logic [31:0]       idx_q;
    logic [31:0]       idx_d;
    logic [7:0]        csum_q;
    logic [31:0]       run_cnt_q;
    logic              rx_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              core_rst_n_q;
    logic              core_en_q;
    logic              done_q;
    logic [1:0]        err_q;
    logic              halt_q;

    logic              byte_acc;
    logic              asm_clr;
    logic              asm_push;
    logic              asm_full;
    logic [XLEN-1:0]   word_d;

    assign byte_acc = i_rx_valid && rx_ready_q;
    assign hdr_d    = {i_rx_data, hdr_q};
    assign idx_d    = idx_q + 32'd1;
    assign asm_clr  = (state_q == IDLE) && byte_acc && (i_rx_data == MAGIC);
    assign asm_push = (state_q == DATA) && byte_acc;

    riscv_boot_word_asm #(
        .XLEN(XLEN)
    ) u_word_asm (
        .clk_i (i_riscv_boot_loader_clk),
        .rst_i (i_riscv_boot_loader_rst),
        .clr_i (asm_clr),
        .push_i(asm_push),
        .byte_i(i_rx_data),
        .word_o(word_d),
        .full_o(asm_full)
    );

    assign o_rx_ready   = rx_ready_q;
    assign o_mem_we     = we_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_core_rst_n = core_rst_n_q;
    assign o_core_en    = core_en_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_halt       = halt_q;

    // Frame parser, memory write handshake and core run control.
    always_ff @(posedge i_riscv_boot_loader_clk) begin
        if (i_riscv_boot_loader_rst) begin
            state_q      <= IDLE;
            hdr_q        <= '0;
            hdr_idx_q    <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            run_cnt_q    <= '0;
            rx_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
            core_en_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= ERR_NONE;
            halt_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (byte_acc && (i_rx_data == MAGIC)) begin
                        hdr_idx_q <= '0;
                        csum_q    <= '0;
                        idx_q     <= '0;
                        state_q   <= HDR_CNT;
                    end
                end
                HDR_CNT: begin
                    if (byte_acc) begin
                        hdr_q     <= hdr_d[31:8];
                        hdr_idx_q <= hdr_idx_q + 3'd1;
                        if (hdr_idx_q == CNT_LAST) begin
                            count_q <= hdr_d;
                            if (hdr_d > 32'(MAX_WORDS)) begin
                                err_q      <= ERR_SIZE;
                                rx_ready_q <= 1'b0;
                                state_q    <= ERROR;
                            end else if (hdr_d == 32'd0) begin
                                state_q <= CHECK;
                            end else begin
                                state_q <= HDR_BASE;
                            end
                        end
                    end
                end
                HDR_BASE: begin
                    if (byte_acc) begin
                        hdr_q     <= hdr_d[31:8];
                        hdr_idx_q <= hdr_idx_q + 3'd1;
                        if (hdr_idx_q == BASE_LAST) begin
                            addr_q  <= hdr_d[ADDR_W-1:0];
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (byte_acc) begin
                        csum_q <= csum_q + i_rx_data;
                        if (asm_full) begin
                            wdata_q    <= word_d;
                            we_q       <= 1'b1;
                            rx_ready_q <= 1'b0;
                            state_q    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // addr_q tracks BASE + idx*BPW incrementally; wrap is intended
                    if (i_mem_ready) begin
                        we_q       <= 1'b0;
                        idx_q      <= idx_d;
                        addr_q     <= addr_q + ADDR_W'(BPW);
                        rx_ready_q <= 1'b1;
                        state_q    <= (idx_d == count_q) ? CHECK : DATA;
                    end
                end
                CHECK: begin
                    if (byte_acc) begin
                        rx_ready_q <= 1'b0;
                        if (i_rx_data == csum_q) begin
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                            core_en_q    <= 1'b1;
                            run_cnt_q    <= '0;
                            state_q      <= RUN;
                        end else begin
                            err_q   <= ERR_CSUM;
                            state_q <= ERROR;
                        end
                    end
                end
                RUN: begin
                    if ((RUN_CYCLES != 0) && (run_cnt_q == RUN_LAST)) begin
                        core_en_q <= 1'b0;
                        halt_q    <= 1'b1;
                        state_q   <= HALT;
                    end else begin
                        run_cnt_q <= run_cnt_q + 32'd1;
                    end
                end
                HALT: begin
                    rx_ready_q <= 1'b0;
                end
                ERROR: begin
                    rx_ready_q   <= 1'b0;
                    core_rst_n_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Directed bench for riscv_boot_loader with a frame-level model of the
// expected memory writes and per-cycle output consistency checks.
module tb_riscv_boot_loader;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned MAX_WORDS  = 4096;
    localparam int unsigned RUN_CYCLES = 4000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ready = 1'b1;
    logic              core_rst_n;
    logic              core_en;
    logic              done;
    logic [1:0]        err;
    logic              halt;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [XLEN-1:0]   exp_data_q[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [XLEN-1:0]   log_data[$];

    always #5 clk = ~clk;

    riscv_boot_loader #(
        .XLEN      (XLEN),
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .RUN_CYCLES(RUN_CYCLES),
        .MAGIC     (8'hA5)
    ) dut (
        .i_riscv_boot_loader_clk(clk),
        .i_riscv_boot_loader_rst(rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ready (mem_ready),
        .o_core_rst_n(core_rst_n),
        .o_core_en   (core_en),
        .o_done      (done),
        .o_err       (err),
        .o_halt      (halt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Every cycle: accepted writes must match the model queue in order,
    // and the status outputs must be mutually consistent.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rx_ready_during_write", 64'(mem_we && rx_ready), 64'd0);
            chk("core_rst_n_vs_done", 64'(core_rst_n), 64'(done));
            chk("halt_with_core_en", 64'(halt && core_en), 64'd0);
            if (mem_we && mem_ready) begin
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
                chk("write_expected", 64'(exp_addr_q.size() != 0), 64'd1);
                if (exp_addr_q.size() != 0) begin
                    chk("wr_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
                    chk("wr_data", mem_wdata, exp_data_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("byte_accepted", 64'(rx_ready), 64'd1);
        if (rx_ready) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic expect_no_accept(input logic [7:0] b);
        bit seen = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_ready) seen = 1;
        end
        chk("no_accept", 64'(seen), 64'd0);
        rx_valid = 1'b0;
    endtask

    // Model: data byte k of the frame is first+k; words are little-endian,
    // addresses advance by 8 per word, checksum is the byte sum mod 256.
    task automatic send_frame(input logic [31:0] count, input logic [31:0] base,
                              input logic [7:0] first, input bit force_csum,
                              input logic [7:0] csum_val, output logic [7:0] model_csum);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [63:0] w;
        sum = '0;
        for (int unsigned i = 0; i < count; i++) begin
            w = '0;
            for (int unsigned j = 0; j < 8; j++) begin
                b = first + 8'(i * 8 + j);
                w = w | (64'(b) << (8 * j));
                sum = sum + b;
            end
            exp_addr_q.push_back(32'(base + i * 8));
            exp_data_q.push_back(w);
        end
        model_csum = sum;
        send_byte(8'hA5);
        for (int unsigned j = 0; j < 4; j++) send_byte(count[8*j +: 8]);
        if (count != 0) begin
            for (int unsigned j = 0; j < 4; j++) send_byte(base[8*j +: 8]);
        end
        for (int unsigned i = 0; i < count * 8; i++) send_byte(first + 8'(i));
        chk("pre_csum_core_rst_n", 64'(core_rst_n), 64'd0);
        send_byte(force_csum ? csum_val : sum);
    endtask

    task automatic do_reset();
        rx_valid  = 1'b0;
        mem_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_addr_q.delete();
        exp_data_q.delete();
        log_addr.delete();
        log_data.delete();
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("rst_core_en", 64'(core_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_halt", 64'(halt), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_rx_ready", 64'(rx_ready), 64'd1);
    endtask

    task automatic stall_first_write();
        int n = 0;
        logic [31:0] a;
        logic [63:0] d;
        @(negedge clk);
        while (!mem_we && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("stall_we_seen", 64'(mem_we), 64'd1);
        a = mem_addr;
        d = mem_wdata;
        chk("stall_addr", 64'(a), 64'h1000);
        chk("stall_data", d, 64'h0807060504030201);
        for (int i = 0; i < 10; i++) begin
            chk("stall_we_hold", 64'(mem_we), 64'd1);
            chk("stall_addr_hold", 64'(mem_addr), 64'(a));
            chk("stall_data_hold", mem_wdata, d);
            chk("stall_rx_ready", 64'(rx_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs;
        int n;

        // Frame A: two words, ready memory
        do_reset();
        send_frame(32'd2, 32'h1000, 8'h01, 1'b0, 8'h00, cs);
        chk("model_csum_A", 64'(cs), 64'h88);
        chk("A_done", 64'(done), 64'd1);
        chk("A_core_rst_n", 64'(core_rst_n), 64'd1);
        chk("A_core_en", 64'(core_en), 64'd1);
        chk("A_err", 64'(err), 64'd0);
        chk("A_rx_ready", 64'(rx_ready), 64'd0);
        chk("A_pending", 64'(exp_addr_q.size()), 64'd0);
        chk("A_wr_count", 64'(log_data.size()), 64'd2);
        if (log_data.size() >= 2) begin
            chk("A_w0_addr", 64'(log_addr[0]), 64'h1000);
            chk("A_w0_data", log_data[0], 64'h0807060504030201);
            chk("A_w1_addr", 64'(log_addr[1]), 64'h1008);
            chk("A_w1_data", log_data[1], 64'h100F0E0D0C0B0A09);
        end

        // Same frame, wrong checksum
        do_reset();
        send_frame(32'd2, 32'h1000, 8'h01, 1'b1, 8'h00, cs);
        @(posedge clk);
        #1;
        chk("B_err", 64'(err), 64'd2);
        chk("B_done", 64'(done), 64'd0);
        chk("B_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("B_rx_ready", 64'(rx_ready), 64'd0);
        expect_no_accept(8'hA5);
        chk("B_err_sticky", 64'(err), 64'd2);

        // Noise then oversize COUNT = MAX_WORDS+1 = 0x1001
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h00);
        chk("C_err_before_last", 64'(err), 64'd0);
        send_byte(8'h00);
        chk("C_err", 64'(err), 64'd1);
        chk("C_done", 64'(done), 64'd0);
        chk("C_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("C_rx_ready", 64'(rx_ready), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("C_no_writes", 64'(log_data.size()), 64'd0);

        // Memory stalls the first write for 10+ cycles
        do_reset();
        mem_ready = 1'b0;
        fork
            stall_first_write();
            send_frame(32'd2, 32'h1000, 8'h01, 1'b0, 8'h00, cs);
        join
        chk("D_done", 64'(done), 64'd1);
        chk("D_wr_count", 64'(log_data.size()), 64'd2);
        chk("D_pending", 64'(exp_addr_q.size()), 64'd0);

        // Empty image, run budget then freeze
        do_reset();
        send_frame(32'd0, 32'h0, 8'h00, 1'b0, 8'h00, cs);
        chk("E_model_csum", 64'(cs), 64'h00);
        chk("E_done", 64'(done), 64'd1);
        chk("E_core_en", 64'(core_en), 64'd1);
        n = 0;
        while (!halt && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("E_halt_cycles", 64'(n), 64'd4000);
        chk("E_halt", 64'(halt), 64'd1);
        chk("E_core_en_off", 64'(core_en), 64'd0);
        chk("E_core_rst_n", 64'(core_rst_n), 64'd1);
        chk("E_done_sticky", 64'(done), 64'd1);
        chk("E_no_writes", 64'(log_data.size()), 64'd0);

        // Reset in the middle of DATA, then a clean frame
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        do_reset();
        send_frame(32'd2, 32'h3000, 8'h21, 1'b0, 8'h00, cs);
        chk("F_done", 64'(done), 64'd1);
        chk("F_err", 64'(err), 64'd0);
        chk("F_wr_count", 64'(log_data.size()), 64'd2);
        if (log_data.size() >= 1) begin
            chk("F_w0_addr", 64'(log_addr[0]), 64'h3000);
            chk("F_w0_data", log_data[0], 64'h2827262524232221);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
